// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared encodings for the RV32IM MEM stage
package riscv_pkg;

   // funct3[1:0] access size; funct3[2] selects zero-extension on loads
   localparam logic [1:0] SIZE_BYTE = 2'b00;
   localparam logic [1:0] SIZE_HALF = 2'b01;
   localparam logic [1:0] SIZE_WORD = 2'b10;

   localparam logic [1:0] WB_ALU = 2'b00;
   localparam logic [1:0] WB_MEM = 2'b01;
   localparam logic [1:0] WB_PC4 = 2'b10;

   typedef enum logic {IDLE, WAIT} mem_state_t;

endpackage

// File: rtl/load_store_align.sv
// rtl/load_store_align.sv - byte-lane steering for stores and load extraction/extension
module load_store_align
   import riscv_pkg::*;
(
   input  logic [1:0]  addr_lo_i,
   input  logic [2:0]  funct3_i,
   input  logic [31:0] rs2_i,
   input  logic [31:0] rdata_i,
   output logic [3:0]  be_o,
   output logic [31:0] wdata_o,
   output logic [31:0] load_data_o,
   output logic        misaligned_o
);

   logic [7:0]  lane_b;
   logic [15:0] lane_h;

   assign lane_b = (addr_lo_i == 2'd0) ? rdata_i[7:0]   :
                   (addr_lo_i == 2'd1) ? rdata_i[15:8]  :
                   (addr_lo_i == 2'd2) ? rdata_i[23:16] : rdata_i[31:24];
   assign lane_h = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];

   always_comb begin
      be_o         = 4'b1111;
      wdata_o      = rs2_i;
      load_data_o  = rdata_i;
      misaligned_o = 1'b0;
      case (funct3_i[1:0])
         SIZE_BYTE: begin
            be_o        = 4'b0001 << addr_lo_i;
            wdata_o     = {4{rs2_i[7:0]}};
            load_data_o = funct3_i[2] ? {24'h0, lane_b} : {{24{lane_b[7]}}, lane_b};
         end
         SIZE_HALF: begin
            be_o         = 4'b0011 << {addr_lo_i[1], 1'b0};
            wdata_o      = {2{rs2_i[15:0]}};
            load_data_o  = funct3_i[2] ? {16'h0, lane_h} : {{16{lane_h[15]}}, lane_h};
            misaligned_o = addr_lo_i[0];
         end
         SIZE_WORD: misaligned_o = (addr_lo_i != 2'b00);
         default: ;
      endcase
   end

endmodule

// File: rtl/memory_access_stage.sv
// rtl/memory_access_stage.sv - MEM stage: data-memory handshake, timeout, MEM/WB register
module memory_access_stage
   import riscv_pkg::*;
#(
   parameter int XLEN    = 32,
   parameter int TIMEOUT = 64
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [XLEN-1:0] ALU_out_EXMEM,
   input  logic [2:0]      funct3_EXMEM,
   input  logic            mem_wr_en_EXMEM,
   input  logic [XLEN-1:0] rs2_data_EXMEM,
   input  logic            reg_wr_en_EXMEM,
   input  logic [1:0]      reg_wr_ctrl_EXMEM,
   input  logic [4:0]      rd_EXMEM,
   input  logic [XLEN-1:0] pc_4_EXMEM,
   input  logic            halt_MEM,
   output logic            dmem_req,
   output logic            dmem_we,
   output logic [XLEN-1:0] dmem_addr,
   output logic [XLEN-1:0] dmem_wdata,
   output logic [3:0]      dmem_be,
   input  logic            dmem_ready,
   input  logic [XLEN-1:0] dmem_rdata,
   output logic            mem_stall,
   output logic [XLEN-1:0] reg_wr_data_MEMWB,
   output logic [4:0]      rd_MEMWB,
   output logic            reg_wr_en_MEMWB,
   output logic            halt_WB,
   output logic            misalign_MEMWB,
   output logic            bus_err_MEMWB
);

   localparam int            CW       = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

   mem_state_t      state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            access, misaligned, timeout;
   logic [XLEN-1:0] load_data, wb_data;

   logic [XLEN-1:0] wr_data_q, wr_data_d;
   logic [4:0]      rd_q, rd_d;
   logic            wr_en_q, wr_en_d;
   logic            halt_q, halt_d;
   logic            mis_q, mis_d;
   logic            berr_q, berr_d;

   assign access = mem_wr_en_EXMEM | (reg_wr_ctrl_EXMEM == WB_MEM);

   load_store_align u_align (
      .addr_lo_i    (ALU_out_EXMEM[1:0]),
      .funct3_i     (funct3_EXMEM),
      .rs2_i        (rs2_data_EXMEM),
      .rdata_i      (dmem_rdata),
      .be_o         (dmem_be),
      .wdata_o      (dmem_wdata),
      .load_data_o  (load_data),
      .misaligned_o (misaligned)
   );

   assign dmem_addr = {ALU_out_EXMEM[XLEN-1:2], 2'b00};
   assign dmem_we   = dmem_req & mem_wr_en_EXMEM;

   always_comb begin
      case (reg_wr_ctrl_EXMEM)
         WB_ALU:  wb_data = ALU_out_EXMEM;
         WB_MEM:  wb_data = load_data;
         WB_PC4:  wb_data = pc_4_EXMEM;
         default: wb_data = '0;
      endcase
   end

   // cnt_q counts request cycles including the issue cycle in IDLE
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      dmem_req  = 1'b0;
      mem_stall = 1'b0;
      timeout   = 1'b0;
      case (state_q)
         IDLE: begin
            if (access && !misaligned) begin
               dmem_req = 1'b1;
               if (!dmem_ready) begin
                  mem_stall = 1'b1;
                  state_d   = WAIT;
                  cnt_d     = CW'(1);
               end
            end
         end
         WAIT: begin
            dmem_req = 1'b1;
            if (dmem_ready) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
               timeout = 1'b1;
               state_d = IDLE;
               cnt_d   = '0;
            end else begin
               mem_stall = 1'b1;
               cnt_d     = cnt_q + CW'(1);
            end
         end
         default: state_d = IDLE;
      endcase
      if (!reset) begin
         dmem_req  = 1'b0;
         mem_stall = 1'b0;
      end
   end

   always_comb begin
      wr_data_d = '0;
      rd_d      = '0;
      wr_en_d   = 1'b0;
      halt_d    = 1'b0;
      mis_d     = 1'b0;
      berr_d    = 1'b0;
      if (!mem_stall) begin
         rd_d   = rd_EXMEM;
         halt_d = halt_MEM;
         if (timeout) begin
            berr_d = 1'b1;
         end else if (access && misaligned) begin
            mis_d = 1'b1;
         end else begin
            wr_en_d   = reg_wr_en_EXMEM & ~mem_wr_en_EXMEM;
            wr_data_d = wb_data;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         wr_data_q <= '0;
         rd_q      <= '0;
         wr_en_q   <= 1'b0;
         halt_q    <= 1'b0;
         mis_q     <= 1'b0;
         berr_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         wr_data_q <= wr_data_d;
         rd_q      <= rd_d;
         wr_en_q   <= wr_en_d;
         halt_q    <= halt_d;
         mis_q     <= mis_d;
         berr_q    <= berr_d;
      end
   end

   assign reg_wr_data_MEMWB = wr_data_q;
   assign rd_MEMWB          = rd_q;
   assign reg_wr_en_MEMWB   = wr_en_q;
   assign halt_WB           = halt_q;
   assign misalign_MEMWB    = mis_q;
   assign bus_err_MEMWB     = berr_q;

endmodule

// File: tb/tb_memory_access_stage.sv
// tb/tb_memory_access_stage.sv - scoreboard bench for memory_access_stage
module tb_memory_access_stage;

   localparam int XLEN    = 32;
   localparam int TIMEOUT = 64;

   logic            clk = 1'b0;
   logic            reset;
   logic [31:0]     ALU_out_EXMEM, rs2_data_EXMEM, pc_4_EXMEM, dmem_rdata;
   logic [2:0]      funct3_EXMEM;
   logic            mem_wr_en_EXMEM, reg_wr_en_EXMEM, halt_MEM, dmem_ready;
   logic [1:0]      reg_wr_ctrl_EXMEM;
   logic [4:0]      rd_EXMEM;
   logic            dmem_req, dmem_we, mem_stall;
   logic [31:0]     dmem_addr, dmem_wdata, reg_wr_data_MEMWB;
   logic [3:0]      dmem_be;
   logic [4:0]      rd_MEMWB;
   logic            reg_wr_en_MEMWB, halt_WB, misalign_MEMWB, bus_err_MEMWB;

   typedef struct packed {
      logic        wen;
      logic [4:0]  rd;
      logic [31:0] data;
      logic        mis;
      logic        berr;
      logic        halt;
   } wb_t;

   wb_t sb[$];
   wb_t mon_e;
   int  checks   = 0;
   int  failures = 0;

   always #5 clk = ~clk;

   memory_access_stage #(.XLEN(XLEN), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .reset(reset),
      .ALU_out_EXMEM(ALU_out_EXMEM), .funct3_EXMEM(funct3_EXMEM),
      .mem_wr_en_EXMEM(mem_wr_en_EXMEM), .rs2_data_EXMEM(rs2_data_EXMEM),
      .reg_wr_en_EXMEM(reg_wr_en_EXMEM), .reg_wr_ctrl_EXMEM(reg_wr_ctrl_EXMEM),
      .rd_EXMEM(rd_EXMEM), .pc_4_EXMEM(pc_4_EXMEM), .halt_MEM(halt_MEM),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
      .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_ready(dmem_ready),
      .dmem_rdata(dmem_rdata), .mem_stall(mem_stall),
      .reg_wr_data_MEMWB(reg_wr_data_MEMWB), .rd_MEMWB(rd_MEMWB),
      .reg_wr_en_MEMWB(reg_wr_en_MEMWB), .halt_WB(halt_WB),
      .misalign_MEMWB(misalign_MEMWB), .bus_err_MEMWB(bus_err_MEMWB)
   );

   // every retiring instruction carries rd != 0; rd == 0 outputs must be clean bubbles
   always @(negedge clk) begin
      if (rd_MEMWB !== 5'd0) begin
         checks++;
         if (sb.size() == 0) begin
            failures++;
            $display("FAIL sb_unexpected rd=%0d got=%h", rd_MEMWB, reg_wr_data_MEMWB);
         end else begin
            mon_e = sb.pop_front();
            if ({reg_wr_en_MEMWB, rd_MEMWB, misalign_MEMWB, bus_err_MEMWB, halt_WB} !==
                {mon_e.wen, mon_e.rd, mon_e.mis, mon_e.berr, mon_e.halt}) begin
               failures++;
               $display("FAIL sb_fields got wen=%b rd=%0d mis=%b berr=%b halt=%b exp wen=%b rd=%0d mis=%b berr=%b halt=%b",
                        reg_wr_en_MEMWB, rd_MEMWB, misalign_MEMWB, bus_err_MEMWB, halt_WB,
                        mon_e.wen, mon_e.rd, mon_e.mis, mon_e.berr, mon_e.halt);
            end
            if (mon_e.wen) begin
               checks++;
               if (reg_wr_data_MEMWB !== mon_e.data) begin
                  failures++;
                  $display("FAIL sb_data rd=%0d got=%h exp=%h", rd_MEMWB, reg_wr_data_MEMWB, mon_e.data);
               end
            end
         end
      end else begin
         checks++;
         if ({reg_wr_en_MEMWB, misalign_MEMWB, bus_err_MEMWB, halt_WB} !== 4'b0000) begin
            failures++;
            $display("FAIL bubble got wen=%b mis=%b berr=%b halt=%b exp 0",
                     reg_wr_en_MEMWB, misalign_MEMWB, bus_err_MEMWB, halt_WB);
         end
      end
   end

   task automatic drive(input logic [31:0] alu, input logic [2:0] f3, input logic we,
                        input logic [31:0] rs2, input logic wen, input logic [1:0] ctrl,
                        input logic [4:0] rd, input logic [31:0] pc4, input logic halt);
      ALU_out_EXMEM     = alu;
      funct3_EXMEM      = f3;
      mem_wr_en_EXMEM   = we;
      rs2_data_EXMEM    = rs2;
      reg_wr_en_EXMEM   = wen;
      reg_wr_ctrl_EXMEM = ctrl;
      rd_EXMEM          = rd;
      pc_4_EXMEM        = pc4;
      halt_MEM          = halt;
   endtask

   task automatic nop();
      drive(32'h0, 3'b000, 1'b0, 32'h0, 1'b0, 2'b00, 5'd0, 32'h0, 1'b0);
      dmem_ready = 1'b0;
   endtask

   // memory answers after lat stall cycles (lat < 0: never); returns at the cycle the stall drops
   task automatic run_instr(input int lat, input logic [31:0] rdata, input int limit,
                            output int stalls, output bit req_seen, output logic [3:0] be_s,
                            output logic [31:0] wd_s, output logic [31:0] addr_s,
                            output logic we_s, output bit done);
      stalls = 0; req_seen = 0; be_s = '0; wd_s = '0; addr_s = '0; we_s = 1'b0; done = 0;
      for (int c = 0; c < limit; c++) begin
         dmem_ready = (lat >= 0) && (c == lat);
         dmem_rdata = rdata;
         #2;
         if (dmem_req === 1'b1) begin
            req_seen = 1; be_s = dmem_be; wd_s = dmem_wdata; addr_s = dmem_addr; we_s = dmem_we;
         end
         if (mem_stall !== 1'b1) begin
            done = 1;
            break;
         end
         stalls++;
         @(negedge clk);
      end
   endtask

   function automatic logic [31:0] model_load(input logic [1:0] lo, input logic [2:0] f3,
                                              input logic [31:0] w);
      logic [31:0] s;
      s = w >> (int'(lo) * 8);
      case (f3)
         3'b000:  return {{24{s[7]}}, s[7:0]};
         3'b100:  return {24'h0, s[7:0]};
         3'b001:  return {{16{s[15]}}, s[15:0]};
         3'b101:  return {16'h0, s[15:0]};
         default: return w;
      endcase
   endfunction

   task automatic test_reset();
      reset = 1'b0;
      drive(32'h100, 3'b010, 1'b0, 32'h0, 1'b1, 2'b01, 5'd1, 32'h0, 1'b1);
      dmem_ready = 1'b0; dmem_rdata = 32'h0;
      repeat (2) @(negedge clk);
      #2;
      checks++;
      if ({dmem_req, mem_stall} !== 2'b00) begin
         failures++;
         $display("FAIL reset_ctrl got req=%b stall=%b exp 0", dmem_req, mem_stall);
      end
      checks++;
      if ({reg_wr_data_MEMWB, rd_MEMWB, reg_wr_en_MEMWB, halt_WB, misalign_MEMWB, bus_err_MEMWB} !== 42'h0) begin
         failures++;
         $display("FAIL reset_memwb got data=%h rd=%0d wen=%b exp 0", reg_wr_data_MEMWB, rd_MEMWB, reg_wr_en_MEMWB);
      end
      @(negedge clk);
      nop();
      reset = 1'b1;
   endtask

   task automatic test_store_word();
      int st; bit rq, dn; logic [3:0] be; logic [31:0] wd, ad; logic we;
      @(negedge clk);
      drive(32'h104, 3'b010, 1'b1, 32'hDEADBEEF, 1'b1, 2'b00, 5'd3, 32'h0, 1'b0);
      sb.push_back('{wen: 1'b0, rd: 5'd3, data: 32'h0, mis: 1'b0, berr: 1'b0, halt: 1'b0});
      run_instr(0, 32'h0, 10, st, rq, be, wd, ad, we, dn);
      checks++;
      if (!(dn && st == 0 && rq)) begin
         failures++;
         $display("FAIL sw_handshake got done=%0d stalls=%0d req=%0d exp 1/0/1", dn, st, rq);
      end
      checks++;
      if ({be, wd, ad, we} !== {4'b1111, 32'hDEADBEEF, 32'h104, 1'b1}) begin
         failures++;
         $display("FAIL sw_bus got be=%b wdata=%h addr=%h we=%b exp 1111 deadbeef 104 1", be, wd, ad, we);
      end
   endtask

   task automatic test_load_byte_wait();
      int st; bit rq, dn; logic [3:0] be; logic [31:0] wd, ad; logic we;
      @(negedge clk);
      drive(32'h103, 3'b000, 1'b0, 32'h0, 1'b1, 2'b01, 5'd4, 32'h0, 1'b0);
      sb.push_back('{wen: 1'b1, rd: 5'd4, data: 32'hFFFFFF80, mis: 1'b0, berr: 1'b0, halt: 1'b0});
      run_instr(3, 32'h80FF0000, 20, st, rq, be, wd, ad, we, dn);
      checks++;
      if (!(dn && st == 3)) begin
         failures++;
         $display("FAIL lb_stall got done=%0d stalls=%0d exp 1/3", dn, st);
      end
      checks++;
      if ({be, ad, we} !== {4'b1000, 32'h100, 1'b0}) begin
         failures++;
         $display("FAIL lb_bus got be=%b addr=%h we=%b exp 1000 100 0", be, ad, we);
      end
   endtask

   task automatic test_halfwords();
      int st; bit rq, dn; logic [3:0] be; logic [31:0] wd, ad; logic we;
      @(negedge clk);
      drive(32'h102, 3'b101, 1'b0, 32'h0, 1'b1, 2'b01, 5'd6, 32'h0, 1'b0);
      sb.push_back('{wen: 1'b1, rd: 5'd6, data: 32'h00008001, mis: 1'b0, berr: 1'b0, halt: 1'b0});
      run_instr(1, 32'h80011234, 10, st, rq, be, wd, ad, we, dn);
      checks++;
      if (!(dn && st == 1 && be == 4'b1100)) begin
         failures++;
         $display("FAIL lhu got done=%0d stalls=%0d be=%b exp 1/1/1100", dn, st, be);
      end
      @(negedge clk);
      drive(32'h102, 3'b001, 1'b1, 32'h0000ABCD, 1'b0, 2'b00, 5'd7, 32'h0, 1'b0);
      sb.push_back('{wen: 1'b0, rd: 5'd7, data: 32'h0, mis: 1'b0, berr: 1'b0, halt: 1'b0});
      run_instr(0, 32'h0, 10, st, rq, be, wd, ad, we, dn);
      checks++;
      if ({be, wd, we} !== {4'b1100, 32'hABCDABCD, 1'b1} || st != 0) begin
         failures++;
         $display("FAIL sh got be=%b wdata=%h we=%b stalls=%0d exp 1100 abcdabcd 1 0", be, wd, we, st);
      end
   endtask

   task automatic test_misaligned();
      int st; bit rq, dn; logic [3:0] be; logic [31:0] wd, ad; logic we;
      @(negedge clk);
      drive(32'h101, 3'b010, 1'b0, 32'h0, 1'b1, 2'b01, 5'd8, 32'h0, 1'b0);
      sb.push_back('{wen: 1'b0, rd: 5'd8, data: 32'h0, mis: 1'b1, berr: 1'b0, halt: 1'b0});
      run_instr(0, 32'h11111111, 10, st, rq, be, wd, ad, we, dn);
      checks++;
      if (rq || st != 0 || !dn) begin
         failures++;
         $display("FAIL lw_misaligned got req=%0d stalls=%0d exp req 0 stalls 0", rq, st);
      end
      @(negedge clk);
      drive(32'h103, 3'b001, 1'b1, 32'h1234, 1'b0, 2'b00, 5'd9, 32'h0, 1'b0);
      sb.push_back('{wen: 1'b0, rd: 5'd9, data: 32'h0, mis: 1'b1, berr: 1'b0, halt: 1'b0});
      run_instr(0, 32'h0, 10, st, rq, be, wd, ad, we, dn);
      checks++;
      if (rq || st != 0) begin
         failures++;
         $display("FAIL sh_misaligned got req=%0d stalls=%0d exp 0 0", rq, st);
      end
      @(negedge clk);
      nop();
   endtask

   task automatic test_timeout();
      int st; bit rq, dn; logic [3:0] be; logic [31:0] wd, ad; logic we;
      @(negedge clk);
      drive(32'h200, 3'b010, 1'b0, 32'h0, 1'b1, 2'b01, 5'd10, 32'h0, 1'b0);
      sb.push_back('{wen: 1'b0, rd: 5'd10, data: 32'h0, mis: 1'b0, berr: 1'b1, halt: 1'b0});
      run_instr(-1, 32'h0, 4 * TIMEOUT, st, rq, be, wd, ad, we, dn);
      checks++;
      if (!(dn && rq && st == TIMEOUT - 1)) begin
         failures++;
         $display("FAIL timeout_stall got done=%0d stalls=%0d exp 1/%0d", dn, st, TIMEOUT - 1);
      end
      @(negedge clk);
      nop();
      #2;
      checks++;
      if ({dmem_req, mem_stall} !== 2'b00) begin
         failures++;
         $display("FAIL timeout_release got req=%b stall=%b exp 0 0", dmem_req, mem_stall);
      end
   endtask

   task automatic test_halt_stall();
      int st; bit rq, dn; logic [3:0] be; logic [31:0] wd, ad; logic we;
      @(negedge clk);
      drive(32'h300, 3'b010, 1'b0, 32'h0, 1'b1, 2'b01, 5'd11, 32'h0, 1'b1);
      sb.push_back('{wen: 1'b1, rd: 5'd11, data: 32'h12345678, mis: 1'b0, berr: 1'b0, halt: 1'b1});
      run_instr(2, 32'h12345678, 10, st, rq, be, wd, ad, we, dn);
      checks++;
      if (!(dn && st == 2)) begin
         failures++;
         $display("FAIL halt_stall got done=%0d stalls=%0d exp 1/2", dn, st);
      end
   endtask

   task automatic test_back_to_back();
      int st; bit rq, dn; logic [3:0] be; logic [31:0] wd, ad; logic we;
      logic [31:0] addr, rdata, val, exp_wd;
      logic [2:0]  f3;
      logic [3:0]  exp_be;
      logic [4:0]  rd;
      int          kind, lat;
      for (int i = 0; i < 16; i++) begin
         kind  = $urandom_range(0, 4);
         lat   = $urandom_range(0, 3);
         rd    = 5'(1 + i);
         val   = $urandom;
         rdata = $urandom;
         addr  = $urandom;
         case ($urandom_range(0, 4))
            0: f3 = 3'b000;  1: f3 = 3'b001;  2: f3 = 3'b010;  3: f3 = 3'b100;
            default: f3 = 3'b101;
         endcase
         if (f3[1:0] == 2'b01) addr[0] = 1'b0;
         if (f3[1:0] == 2'b10) addr[1:0] = 2'b00;
         @(negedge clk);
         if (kind == 0) begin
            drive(addr, f3, 1'b0, 32'h0, 1'b1, 2'b01, rd, 32'h0, 1'b0);
            sb.push_back('{wen: 1'b1, rd: rd, data: model_load(addr[1:0], f3, rdata), mis: 1'b0, berr: 1'b0, halt: 1'b0});
         end else if (kind == 1) begin
            drive(addr, {1'b0, f3[1:0]}, 1'b1, val, 1'b0, 2'b00, rd, 32'h0, 1'b0);
            sb.push_back('{wen: 1'b0, rd: rd, data: 32'h0, mis: 1'b0, berr: 1'b0, halt: 1'b0});
         end else if (kind == 2) begin
            drive(val, 3'b000, 1'b0, 32'h0, 1'b1, 2'b00, rd, 32'h0, 1'b0);
            sb.push_back('{wen: 1'b1, rd: rd, data: val, mis: 1'b0, berr: 1'b0, halt: 1'b0});
         end else if (kind == 3) begin
            drive(val, 3'b000, 1'b0, 32'h0, 1'b1, 2'b10, rd, rdata, 1'b0);
            sb.push_back('{wen: 1'b1, rd: rd, data: rdata, mis: 1'b0, berr: 1'b0, halt: 1'b0});
         end else begin
            drive(val, 3'b000, 1'b0, 32'h0, 1'b1, 2'b11, rd, rdata, 1'b0);
            sb.push_back('{wen: 1'b1, rd: rd, data: 32'h0, mis: 1'b0, berr: 1'b0, halt: 1'b0});
         end
         run_instr(lat, rdata, 10, st, rq, be, wd, ad, we, dn);
         checks++;
         if (!dn || st != ((kind <= 1) ? lat : 0)) begin
            failures++;
            $display("FAIL b2b_stall i=%0d kind=%0d got stalls=%0d done=%0d lat=%0d", i, kind, st, dn, lat);
         end
         if (kind == 1) begin
            case (f3[1:0])
               2'b00:   begin exp_be = 4'b0001 << addr[1:0]; exp_wd = {4{val[7:0]}}; end
               2'b01:   begin exp_be = addr[1] ? 4'b1100 : 4'b0011; exp_wd = {2{val[15:0]}}; end
               default: begin exp_be = 4'b1111; exp_wd = val; end
            endcase
            checks++;
            if ({be, wd, ad} !== {exp_be, exp_wd, addr[31:2], 2'b00}) begin
               failures++;
               $display("FAIL b2b_store i=%0d got be=%b wdata=%h addr=%h exp be=%b wdata=%h",
                        i, be, wd, ad, exp_be, exp_wd);
            end
         end
      end
      @(negedge clk);
      nop();
   endtask

   task automatic test_reset_mid_wait();
      int st; bit rq, dn; logic [3:0] be; logic [31:0] wd, ad; logic we;
      @(negedge clk);
      drive(32'h55, 3'b000, 1'b0, 32'h0, 1'b1, 2'b10, 5'd12, 32'h20, 1'b0);
      sb.push_back('{wen: 1'b1, rd: 5'd12, data: 32'h20, mis: 1'b0, berr: 1'b0, halt: 1'b0});
      run_instr(0, 32'h0, 10, st, rq, be, wd, ad, we, dn);
      @(negedge clk);
      drive(32'h400, 3'b010, 1'b0, 32'h0, 1'b1, 2'b01, 5'd13, 32'h0, 1'b1);
      run_instr(-1, 32'h0, 3, st, rq, be, wd, ad, we, dn);
      checks++;
      if (dn || st != 3) begin
         failures++;
         $display("FAIL rst_wait_pre got done=%0d stalls=%0d exp 0/3", dn, st);
      end
      reset = 1'b0;
      #2;
      checks++;
      if ({dmem_req, mem_stall, reg_wr_en_MEMWB, rd_MEMWB, halt_WB} !== 9'h0) begin
         failures++;
         $display("FAIL rst_wait_async got req=%b stall=%b wen=%b rd=%0d halt=%b exp 0",
                  dmem_req, mem_stall, reg_wr_en_MEMWB, rd_MEMWB, halt_WB);
      end
      @(negedge clk);
      nop();
      reset = 1'b1;
      @(negedge clk);
      #2;
      checks++;
      if ({dmem_req, mem_stall, reg_wr_data_MEMWB} !== 34'h0) begin
         failures++;
         $display("FAIL rst_wait_idle got req=%b stall=%b data=%h exp 0", dmem_req, mem_stall, reg_wr_data_MEMWB);
      end
      @(negedge clk);
      drive(32'h404, 3'b010, 1'b0, 32'h0, 1'b1, 2'b01, 5'd14, 32'h0, 1'b0);
      sb.push_back('{wen: 1'b1, rd: 5'd14, data: 32'hCAFEF00D, mis: 1'b0, berr: 1'b0, halt: 1'b0});
      run_instr(1, 32'hCAFEF00D, 10, st, rq, be, wd, ad, we, dn);
      checks++;
      if (!(dn && st == 1)) begin
         failures++;
         $display("FAIL rst_wait_resume got done=%0d stalls=%0d exp 1/1", dn, st);
      end
      @(negedge clk);
      nop();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_store_word();
      test_load_byte_wait();
      test_halfwords();
      test_misaligned();
      test_timeout();
      test_halt_stall();
      test_back_to_back();
      test_reset_mid_wait();
      repeat (3) @(negedge clk);
      checks++;
      if (sb.size() != 0) begin
         failures++;
         $display("FAIL sb_leftover got=%0d exp=0", sb.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
